bus_req_queue: RTL and testbench
================================

// Module: bus_req_queue
// PURPOSE
//  Request FIFO in front of bus_controller's work-unit port (MOD_*). Accepts 16-byte line
//  read/write requests from a cache/DMA client, issues them one at a time, and returns one
//  response per request with the 128-bit read data.
//  Decouples client bursts from bus arbitration latency; strictly in-order, one transaction outstanding.
// PARAMETERS
//  DEPTH    4    queue entries; power of two, 2..16
//  AW       16   address width; matches MOD_A
//  DW       128  line data width; matches MOD_WRITE_DATA/MOD_READ_DATA
//  TIMEOUT  255  cycles in WAIT before abort; used only with BUS_REQ_QUEUE_TIMEOUT_EN
// PORTS
//  BUS_CLK         in   1    bus clock, rising-edge
//  RST             in   1    asynchronous reset, active-high
//  REQ_V           in   1    client request valid
//  REQ_WR          in   1    1=write, 0=read
//  REQ_A           in   AW   line address
//  REQ_WDATA       in   DW   write data
//  REQ_RDY         out  1    queue not full; push occurs when REQ_V & REQ_RDY at edge
//  MOD_EN          out  1    to bus_controller: transaction request
//  MOD_WR          out  1    to bus_controller: head entry direction
//  MOD_A           out  AW   to bus_controller: head entry address
//  MOD_WRITE_DATA  out  DW   to bus_controller: head entry data
//  MOD_READ_DATA   in   DW   from bus_controller: read buffer
//  MOD_R           in   1    from bus_controller: one-cycle done pulse
//  RESP_V          out  1    one-cycle response pulse
//  RESP_WR         out  1    direction of completed request
//  RESP_A          out  AW   address of completed request
//  RESP_RDATA      out  DW   MOD_READ_DATA captured at completion (reads); 0 for writes
//  RESP_ERR        out  1    completion was a timeout abort (0 when macro absent)
//  COUNT           out  log2(DEPTH)+1  occupied entries, including the in-flight head
// BEHAVIOUR
//  Reset: pointers=0, COUNT=0, state=IDLE; REQ_RDY=1; MOD_EN, RESP_V, RESP_ERR=0;
//   RESP_WR, RESP_A, RESP_RDATA=0. MOD_WR/MOD_A/MOD_WRITE_DATA follow the head entry (don't-care when empty).
//  FIFO: circular, wr_ptr/rd_ptr wrap mod DEPTH; REQ_RDY = (COUNT != DEPTH).
//   Push and pop in the same edge: COUNT unchanged. Push while full is ignored; entry contents unaffected.
//   The head entry remains in storage until its completion; MOD_* are driven straight from head storage.
//  FSM (one-hot):
//   IDLE : COUNT!=0 -> ISSUE.
//   ISSUE: MOD_EN=1 for one cycle; -> WAIT.
//   WAIT : MOD_EN = ~MOD_R (combinational), so EN is already low in the cycle
//          bus_controller returns to IDLE, preventing a spurious re-arbitration.
//          MOD_R=1 -> RESP: pop head; register RESP_*; RDATA=MOD_READ_DATA if read.
//   RESP : RESP_V=1 for exactly one cycle; -> ISSUE if COUNT!=0 after pop, else IDLE.
//  Latency: push into empty queue -> MOD_EN high 2 edges later. Completion: MOD_R edge -> RESP_V next cycle.
//  Head fields are stable from ISSUE through the MOD_R edge; a push never alters the head.
//  MOD_R outside WAIT is ignored (no pop, no response).
//  RST mid-transaction: queue flushed, no response generated; bus_controller is reset by the same RST.
// CONFIGURATION
//  BUS_REQ_QUEUE_TIMEOUT_EN defined: 8-bit wait counter, cleared on WAIT entry, +1 per WAIT cycle.
//   Reaching TIMEOUT without MOD_R: pop head, RESP_V=1 with RESP_ERR=1, RESP_RDATA=0;
//   MOD_EN forced 0 in that cycle. MOD_R and expiry in the same cycle: MOD_R wins, ERR=0.
//  Undefined: no counter; WAIT lasts until MOD_R; RESP_ERR tied 0.
// TESTING
//  1 Reset: assert RST mid-cycle async -> REQ_RDY=1, COUNT=0, MOD_EN=0, RESP_V=0 immediately.
//  2 Single read A=16'h0040: MOD_EN high 2 cycles after push; MOD_R with READ_DATA=128'hA5..A5 ->
//    next cycle RESP_V=1, RESP_WR=0, RESP_A=16'h0040, RESP_RDATA=128'hA5..A5; COUNT back to 0.
//  3 Fill: 5 back-to-back pushes, DEPTH=4, MOD_R withheld -> 4 accepted, REQ_RDY=0, COUNT=4;
//    5th ignored; responses come in push order, addresses match.
//  4 Simultaneous push and pop at COUNT=4 -> push refused (REQ_RDY=0 that cycle), COUNT=3 after.
//    At COUNT=2 with RDY=1 -> push accepted, COUNT stays 2.
//  5 Wrap: 10 write requests through DEPTH=4 -> all 10 responses in order, RESP_RDATA=0,
//    MOD_EN low in every MOD_R cycle.
//  6 Timeout (macro on, TIMEOUT=8): no MOD_R -> RESP_V=1, RESP_ERR=1 after 8 WAIT cycles;
//    next entry is then issued.

Source files
------------

// File: rtl/bus_req_queue_if.sv
// Client request/response and bus_controller work-unit signals
// bundled for bus_req_queue; slave = queue side, master = client/bus side.
interface bus_req_queue_if #(
   parameter int AW    = 16,
   parameter int DW    = 128,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          req_v;
   logic          req_wr;
   logic [AW-1:0] req_a;
   logic [DW-1:0] req_wdata;
   logic          req_rdy;

   logic          mod_en;
   logic          mod_wr;
   logic [AW-1:0] mod_a;
   logic [DW-1:0] mod_write_data;
   logic [DW-1:0] mod_read_data;
   logic          mod_r;

   logic          resp_v;
   logic          resp_wr;
   logic [AW-1:0] resp_a;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;

   logic [CW-1:0] count;

   modport slave (
      input  req_v, req_wr, req_a, req_wdata,
      input  mod_read_data, mod_r,
      output req_rdy,
      output mod_en, mod_wr, mod_a, mod_write_data,
      output resp_v, resp_wr, resp_a, resp_rdata, resp_err,
      output count
   );

   modport master (
      output req_v, req_wr, req_a, req_wdata,
      output mod_read_data, mod_r,
      input  req_rdy,
      input  mod_en, mod_wr, mod_a, mod_write_data,
      input  resp_v, resp_wr, resp_a, resp_rdata, resp_err,
      input  count
   );
endinterface

// File: rtl/bus_req_queue.sv
// In-order line request queue in front of bus_controller, one transaction
// outstanding. Optional WAIT timeout abort: define BUS_REQ_QUEUE_TIMEOUT_EN.
module bus_req_queue #(
   parameter int DEPTH   = 4,
   parameter int AW      = 16,
   parameter int DW      = 128,
   parameter int TIMEOUT = 255
) (
   input logic           bus_clk,
   input logic           rst,
   bus_req_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("bus_req_queue: unsupported DEPTH or TIMEOUT");
   end

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      ISSUE = 4'b0010,
      WAIT  = 4'b0100,
      RESP  = 4'b1000
   } state_t;

   state_t state, state_nx;

   logic          mem_wr [DEPTH];
   logic [AW-1:0] mem_a  [DEPTH];
   logic [DW-1:0] mem_d  [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop, done, expire;

   assign bus.req_rdy = (count != CW'(DEPTH));
   assign bus.count   = count;
   assign push        = bus.req_v & bus.req_rdy;
   assign done        = (state == WAIT) & bus.mod_r;
   assign pop         = done | expire;

   // head entry is presented to the bus straight from storage
   assign bus.mod_wr         = mem_wr[rd_ptr];
   assign bus.mod_a          = mem_a[rd_ptr];
   assign bus.mod_write_data = mem_d[rd_ptr];
   assign bus.resp_v         = (state == RESP);

`ifdef BUS_REQ_QUEUE_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;

   assign expire = (state == WAIT) & ~bus.mod_r & (wait_cnt == WAIT_LAST);

   // count WAIT cycles; held at zero outside WAIT so each entry starts fresh
   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (state != WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 8'd1;
   end
`else
   assign expire = 1'b0;
`endif

   // entry storage: written at the tail only, so the head never moves under a push
   always_ff @(posedge bus_clk) begin
      if (push) begin
         mem_wr[wr_ptr] <= bus.req_wr;
         mem_a[wr_ptr]  <= bus.req_a;
         mem_d[wr_ptr]  <= bus.req_wdata;
      end
   end

   // circular pointers and occupancy (head counted until it completes)
   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // transaction state register
   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next state and bus request; EN drops combinationally on the done pulse
   always_comb begin
      state_nx   = state;
      bus.mod_en = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0)
               state_nx = ISSUE;
         end
         ISSUE: begin
            bus.mod_en = 1'b1;
            state_nx   = WAIT;
         end
         WAIT: begin
            bus.mod_en = ~bus.mod_r & ~expire;
            if (pop)
               state_nx = RESP;
         end
         RESP: begin
            state_nx = (count != '0) ? ISSUE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // capture the completed head into the response registers
   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         bus.resp_wr    <= 1'b0;
         bus.resp_a     <= '0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else if (pop) begin
         bus.resp_wr    <= mem_wr[rd_ptr];
         bus.resp_a     <= mem_a[rd_ptr];
         bus.resp_rdata <= (done & ~mem_wr[rd_ptr]) ? bus.mod_read_data : '0;
         bus.resp_err   <= ~done;
      end
   end
endmodule

// File: tb/tb_bus_req_queue.sv
// Directed bench for bus_req_queue: transaction-level queue model
// checked every cycle, plus hand-computed literal expectations.
module tb_bus_req_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int DW    = 128;
`ifdef BUS_REQ_QUEUE_TIMEOUT_EN
   localparam int TO    = 8;
   localparam bit TO_ON = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_ON = 1'b0;
`endif

   logic bus_clk = 1'b0;
   logic rst     = 1'b1;

   bus_req_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

   bus_req_queue #(
      .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TO)
   ) dut (
      .bus_clk(bus_clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 bus_clk = ~bus_clk;

   int pass_n  = 0;
   int total_n = 0;
   bit run     = 1'b0;
   bit hold    = 1'b0;
   int lat     = 1;
   int wcnt    = 0;
   int cyc     = 0;
   int n_resp  = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total_n++;
      if (act === exp)
         pass_n++;
      else
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   task automatic bound_fail(input string nm);
      total_n++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   bit            m_iss, m_wait, m_resp, m_rerr;
   int            m_wn;
   ent_t          m_re;
   logic [DW-1:0] m_rdata;
   bit            fin, tout, nx_iss, nx_wait;
   int            sz;
   ent_t          e_in;

   always @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_iss  = 1'b0;
         m_wait = 1'b0;
         m_resp = 1'b0;
         m_wn   = 0;
      end else begin
         sz      = mq.size();
         fin     = m_wait && bus.mod_r;
         tout    = TO_ON && m_wait && !bus.mod_r && (m_wn == TO);
         nx_iss  = !m_iss && !m_wait && (sz != 0);
         nx_wait = m_iss || (m_wait && !fin && !tout);
         m_resp  = fin || tout;
         if (m_resp) begin
            m_re    = mq.pop_front();
            m_rerr  = tout;
            m_rdata = (fin && !m_re.wr) ? bus.mod_read_data : '0;
         end
         if (bus.req_v && sz != DEPTH) begin
            e_in.wr = bus.req_wr;
            e_in.a  = bus.req_a;
            e_in.d  = bus.req_wdata;
            mq.push_back(e_in);
         end
         m_wn   = nx_wait ? m_wn + 1 : 0;
         m_iss  = nx_iss;
         m_wait = nx_wait;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge bus_clk) begin
      if (run && !rst) begin
         chk("req_rdy", DW'(bus.req_rdy), DW'(mq.size() != DEPTH));
         chk("count", DW'(bus.count), DW'(mq.size()));
         chk("mod_en", DW'(bus.mod_en),
             DW'(m_iss || (m_wait && !bus.mod_r &&
                           !(TO_ON && m_wn == TO))));
         chk("resp_v", DW'(bus.resp_v), DW'(m_resp));
         if (m_resp) begin
            chk("resp_wr", DW'(bus.resp_wr), DW'(m_re.wr));
            chk("resp_a", DW'(bus.resp_a), DW'(m_re.a));
            chk("resp_rdata", bus.resp_rdata, m_rdata);
            chk("resp_err", DW'(bus.resp_err), DW'(m_rerr));
         end
         if (m_iss || m_wait) begin
            chk("mod_wr", DW'(bus.mod_wr), DW'(mq[0].wr));
            chk("mod_a", DW'(bus.mod_a), DW'(mq[0].a));
            chk("mod_wdata", bus.mod_write_data, mq[0].d);
         end
         if (bus.mod_r)
            chk("en_in_r", DW'(bus.mod_en), '0);
         if (bus.resp_v)
            n_resp++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(posedge bus_clk);
      #1;
      cyc++;
      if (bus.mod_r) begin
         bus.mod_r = 1'b0;
      end else if (bus.mod_en && !rst) begin
         wcnt++;
         if (!hold && wcnt > lat) begin
            bus.mod_r         = 1'b1;
            bus.mod_read_data = {8{bus.mod_a ^ 16'hA5E5}};
            wcnt              = 0;
         end
      end else begin
         wcnt = 0;
      end
      #1;
   endtask

   task automatic push(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      bus.req_v     = 1'b1;
      bus.req_wr    = wr;
      bus.req_a     = a;
      bus.req_wdata = d;
      nxt();
      bus.req_v = 1'b0;
   endtask

   task automatic wait_resp(input string nm, input int lim);
      bit got;
      got = 1'b0;
      for (int i = 0; i < lim && !got; i++) begin
         nxt();
         got = bus.resp_v;
      end
      if (!got)
         bound_fail(nm);
   endtask

   task automatic drain(input string nm, input int lim);
      bit empty;
      empty = 1'b0;
      for (int i = 0; i < lim && !empty; i++) begin
         nxt();
         empty = (bus.count == '0) && !bus.resp_v;
      end
      if (!empty)
         bound_fail(nm);
   endtask

   logic [AW-1:0] exp_a [4];
   int            r0;
   int            t0;
   bit            acc;
   bit            found;

   initial begin
      bus.req_v         = 1'b0;
      bus.req_wr        = 1'b0;
      bus.req_a         = '0;
      bus.req_wdata     = '0;
      bus.mod_r         = 1'b0;
      bus.mod_read_data = '0;
      nxt();
      nxt();
      rst = 1'b0;
      run = 1'b1;
      nxt();

      // async reset in the middle of a cycle with work queued
      hold = 1'b1;
      push(1'b0, 16'h0010, '0);
      push(1'b1, 16'h0020, '1);
      nxt();
      chk("pre_rst_count", DW'(bus.count), DW'(2));
      #1;
      rst = 1'b1;
      #1;
      chk("rst_rdy", DW'(bus.req_rdy), DW'(1));
      chk("rst_count", DW'(bus.count), '0);
      chk("rst_en", DW'(bus.mod_en), '0);
      chk("rst_resp_v", DW'(bus.resp_v), '0);
      chk("rst_resp_a", DW'(bus.resp_a), '0);
      chk("rst_rdata", bus.resp_rdata, '0);
      nxt();
      nxt();
      rst  = 1'b0;
      hold = 1'b0;
      nxt();

      // single read
      push(1'b0, 16'h0040, '0);
      chk("rd_count1", DW'(bus.count), DW'(1));
      chk("rd_en_early", DW'(bus.mod_en), '0);
      nxt();
      chk("rd_en_issue", DW'(bus.mod_en), DW'(1));
      chk("rd_mod_a", DW'(bus.mod_a), DW'(16'h0040));
      wait_resp("rd_resp", 20);
      chk("rd_resp_wr", DW'(bus.resp_wr), '0);
      chk("rd_resp_a", DW'(bus.resp_a), DW'(16'h0040));
      chk("rd_rdata", bus.resp_rdata, {16{8'hA5}});
      chk("rd_count0", DW'(bus.count), '0);
      nxt();

      // fill with bus withheld: fifth push dropped
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.req_v     = 1'b1;
         bus.req_wr    = 1'b0;
         bus.req_a     = AW'(16'h0100 + i * 16);
         bus.req_wdata = '0;
         nxt();
      end
      bus.req_v = 1'b0;
      chk("fill_count", DW'(bus.count), DW'(4));
      chk("fill_rdy", DW'(bus.req_rdy), '0);
      exp_a[0] = 16'h0100;
      exp_a[1] = 16'h0110;
      exp_a[2] = 16'h0120;
      exp_a[3] = 16'h0130;
      hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_resp("fill_resp", 20);
         chk("fill_order", DW'(bus.resp_a), DW'(exp_a[i]));
      end
      drain("fill_drain", 20);

      // push against pop at full, then at COUNT=2
      hold = 1'b1;
      push(1'b0, 16'h0200, '0);
      push(1'b0, 16'h0210, '0);
      push(1'b0, 16'h0220, '0);
      push(1'b0, 16'h0230, '0);
      nxt();
      nxt();
      bus.req_v     = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_a     = 16'h02F0;
      bus.req_wdata = '1;
      hold          = 1'b0;
      nxt();
      chk("full_pop_rdy", DW'(bus.req_rdy), '0);
      chk("full_pop_cnt", DW'(bus.count), DW'(4));
      nxt();
      bus.req_v = 1'b0;
      chk("full_after", DW'(bus.count), DW'(3));
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         found = bus.mod_r && (bus.count == 3'd2);
         if (!found)
            nxt();
      end
      if (!found)
         bound_fail("cnt2_wait");
      bus.req_v     = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_a     = 16'h0300;
      bus.req_wdata = '0;
      nxt();
      bus.req_v = 1'b0;
      chk("cnt2_after", DW'(bus.count), DW'(2));
      drain("cnt2_drain", 40);
      chk("cnt2_last_a", DW'(bus.resp_a), DW'(16'h0300));

      // ten writes through the ring
      lat = 2;
      r0  = n_resp;
      for (int i = 0; i < 10; i++) begin
         bus.req_v     = 1'b1;
         bus.req_wr    = 1'b1;
         bus.req_a     = AW'(16'h0400 + i * 16);
         bus.req_wdata = {8{16'(i * 3 + 1)}};
         acc = 1'b0;
         for (int k = 0; k < 30 && !acc; k++) begin
            acc = bus.req_rdy;
            nxt();
         end
         if (!acc)
            bound_fail("wrap_push");
      end
      bus.req_v = 1'b0;
      drain("wrap_drain", 60);
      chk("wrap_n_resp", DW'(n_resp - r0), DW'(10));
      chk("wrap_last_a", DW'(bus.resp_a), DW'(16'h0490));
      chk("wrap_rdata", bus.resp_rdata, '0);

`ifdef BUS_REQ_QUEUE_TIMEOUT_EN
      // timeout abort, then next entry issues
      lat  = 1;
      hold = 1'b1;
      push(1'b1, 16'h0500, '1);
      push(1'b0, 16'h0510, '0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         found = bus.mod_en;
         if (!found)
            nxt();
      end
      if (!found)
         bound_fail("to_issue");
      t0 = cyc;
      wait_resp("to_resp", 20);
      chk("to_latency", DW'(cyc - t0), DW'(9));
      chk("to_err", DW'(bus.resp_err), DW'(1));
      chk("to_a", DW'(bus.resp_a), DW'(16'h0500));
      chk("to_rdata", bus.resp_rdata, '0);
      nxt();
      chk("to_next_en", DW'(bus.mod_en), DW'(1));
      chk("to_next_a", DW'(bus.mod_a), DW'(16'h0510));
      hold = 1'b0;
      wait_resp("to_resp2", 20);
      chk("to_err2", DW'(bus.resp_err), '0);
      drain("to_drain", 20);
`endif

      nxt();
      run = 1'b0;
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
